// File: rtl/i2c_pkg.sv
// Shared types for the I2C register sequencer: response status codes,
// sequencer states and the R/W bit values placed in the address byte.
package i2c_pkg;

  typedef enum logic [2:0] {
    OK        = 3'd0,
    ADDR_NACK = 3'd1,
    DATA_NACK = 3'd2,
    ARB_LOST  = 3'd3,
    TIMEOUT   = 3'd4
  } i2c_status_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REG_HI = 3'd1,
    REG_LO = 3'd2,
    WDATA  = 3'd3,
    RDATA  = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_watchdog.sv
// Watchdog down-counter. It reloads on clear, decrements while enabled and
// holds at zero; expired is raised while the count sits at zero, which
// happens CYCLES-1 enabled cycles after the last clear.
module i2c_watchdog #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] count;

  // Reload on clear, otherwise count down towards zero while enabled.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-access front end for the I2C master: expands one register
// read/write request into device-address, pointer and data bytes, and
// returns a single response with read data and a status code.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int REG_ADDR_BYTES = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [6:0]  req_dev,
  input  logic [15:0] req_reg,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [2:0]  rsp_status,
  output logic [7:0]  m_address,
  output logic        m_transfer_start,
  output logic        m_transfer_continues,
  output logic [7:0]  m_data_tx,
  input  logic        m_transfer_ready,
  input  logic        m_interrupt,
  input  logic        m_transaction_complete,
  input  logic        m_nack,
  input  logic        m_address_err,
  input  logic        m_arbitration_err,
  input  logic [7:0]  m_data_rx
);

  seq_state_t  state, state_next;
  i2c_status_t status_q, status_next;
  logic [7:0]  rdata_q, rdata_next;
  logic        first_q, first_next;
  logic        read_q;
  logic [6:0]  dev_q;
  logic [15:0] reg_q;
  logic [7:0]  wdata_q;
  logic        wd_clear, wd_enable, wd_expired;
  logic        accept;
  logic        unused_inputs;

  // The master's byte-ready flag carries no information this sequencer needs.
  assign unused_inputs = &{1'b0, m_transfer_ready};

  assign accept = (state == IDLE) && req_valid;

  i2c_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_in  (clk_in),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State, response and first-byte START tracking registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      status_q <= OK;
      rdata_q  <= 8'h00;
      first_q  <= 1'b0;
    end else begin
      state    <= state_next;
      status_q <= status_next;
      rdata_q  <= rdata_next;
      first_q  <= first_next;
    end
  end

  // Capture the request fields on the accept cycle; held for the whole transaction.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      read_q  <= RW_WRITE;
      dev_q   <= 7'h00;
      reg_q   <= 16'h0000;
      wdata_q <= 8'h00;
    end else if (accept) begin
      read_q  <= req_read;
      dev_q   <= req_dev;
      reg_q   <= req_reg;
      wdata_q <= req_wdata;
    end
  end

  // Next-state logic: advance on clean byte completion, abort on errors or watchdog.
  always_comb begin
    state_next  = state;
    status_next = status_q;
    rdata_next  = rdata_q;
    first_next  = first_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next  = (REG_ADDR_BYTES == 2) ? REG_HI : REG_LO;
          status_next = OK;
          rdata_next  = 8'h00;
          first_next  = 1'b1;
          wd_clear    = 1'b1;
        end
      end
      REG_HI, REG_LO, WDATA, RDATA: begin
        wd_enable = 1'b1;
        if (m_interrupt) begin
          wd_clear   = 1'b1;
          first_next = 1'b0;
          if (m_arbitration_err) begin
            state_next  = DONE;
            status_next = ARB_LOST;
            rdata_next  = 8'h00;
          end else if (m_address_err) begin
            state_next  = DONE;
            status_next = ADDR_NACK;
            rdata_next  = 8'h00;
          end else if (m_transaction_complete && m_nack && (state != RDATA)) begin
            state_next  = DONE;
            status_next = DATA_NACK;
            rdata_next  = 8'h00;
          end else if (m_transaction_complete) begin
            case (state)
              REG_HI:  state_next = REG_LO;
              REG_LO:  state_next = (read_q == RW_READ) ? RDATA : WDATA;
              RDATA: begin
                rdata_next = m_data_rx;
                state_next = DONE;
              end
              default: state_next = DONE;
            endcase
          end
        end else if (wd_expired) begin
          state_next  = DONE;
          status_next = TIMEOUT;
          rdata_next  = 8'h00;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Master-side byte presentation, derived purely from the current state.
  always_comb begin
    m_address            = 8'h00;
    m_data_tx            = 8'h00;
    m_transfer_continues = 1'b0;
    m_transfer_start     = 1'b0;
    case (state)
      REG_HI: begin
        m_address            = {dev_q, RW_WRITE};
        m_data_tx            = reg_q[15:8];
        m_transfer_continues = 1'b1;
        m_transfer_start     = first_q;
      end
      REG_LO: begin
        m_address            = {dev_q, RW_WRITE};
        m_data_tx            = reg_q[7:0];
        m_transfer_continues = (read_q == RW_WRITE);
        m_transfer_start     = first_q || (read_q == RW_READ);
      end
      WDATA: begin
        m_address        = {dev_q, RW_WRITE};
        m_data_tx        = wdata_q;
        m_transfer_start = first_q;
      end
      RDATA: begin
        m_address        = {dev_q, RW_READ};
        m_transfer_start = first_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: two instances (1- and 2-byte
// register pointers), a behavioural I2C master model, and a response monitor.
module tb_i2c_reg_sequencer;
  import i2c_pkg::*;

  localparam int F_NONE   = 0;
  localparam int F_ADDR   = 1;
  localparam int F_ARB    = 2;
  localparam int F_NACK   = 3;
  localparam int F_SILENT = 4;
  localparam int D_READ   = 5;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       chk_data;
    logic       cont;
    logic       start;
    int         drive;
    logic [7:0] rx;
  } byte_t;

  typedef struct {
    logic [2:0] status;
    logic [7:0] rdata;
    logic       tmo;
  } rsp_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        reset, sel;
  logic        req_valid, req_read;
  logic [6:0]  req_dev;
  logic [15:0] req_reg;
  logic [7:0]  req_wdata;
  logic        mi, mc, mn, mae, marb, mtr;
  logic [7:0]  mrx;

  logic        rdy [2];
  logic        rv  [2];
  logic [7:0]  rd  [2];
  logic [2:0]  rs  [2];
  logic [7:0]  ma  [2];
  logic [7:0]  mdt [2];
  logic        ms  [2];
  logic        mcn [2];

  logic        cur_ready, cur_rv, cur_start, cur_cont;
  logic [7:0]  cur_rdata, cur_addr, cur_data;
  logic [2:0]  cur_status;

  assign cur_ready  = sel ? rdy[1] : rdy[0];
  assign cur_rv     = sel ? rv[1]  : rv[0];
  assign cur_rdata  = sel ? rd[1]  : rd[0];
  assign cur_status = sel ? rs[1]  : rs[0];
  assign cur_addr   = sel ? ma[1]  : ma[0];
  assign cur_data   = sel ? mdt[1] : mdt[0];
  assign cur_start  = sel ? ms[1]  : ms[0];
  assign cur_cont   = sel ? mcn[1] : mcn[0];

  i2c_reg_sequencer #(.REG_ADDR_BYTES(1), .TIMEOUT_CYCLES(16)) dut0 (
    .clk_in(clk_in), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(rdy[0]), .req_read(req_read),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_status(rs[0]),
    .m_address(ma[0]), .m_transfer_start(ms[0]), .m_transfer_continues(mcn[0]),
    .m_data_tx(mdt[0]), .m_transfer_ready(mtr), .m_interrupt(mi),
    .m_transaction_complete(mc), .m_nack(mn), .m_address_err(mae),
    .m_arbitration_err(marb), .m_data_rx(mrx)
  );

  i2c_reg_sequencer #(.REG_ADDR_BYTES(2), .TIMEOUT_CYCLES(16)) dut1 (
    .clk_in(clk_in), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(rdy[1]), .req_read(req_read),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_status(rs[1]),
    .m_address(ma[1]), .m_transfer_start(ms[1]), .m_transfer_continues(mcn[1]),
    .m_data_tx(mdt[1]), .m_transfer_ready(mtr), .m_interrupt(mi),
    .m_transaction_complete(mc), .m_nack(mn), .m_address_err(mae),
    .m_arbitration_err(marb), .m_data_rx(mrx)
  );

  byte_t byte_q[$];
  rsp_t  rsp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    clear_cyc = 0;
  int    byte_idx = 0;
  int    silent_at = -1;
  int    done_count = 0;

  // Free-running cycle count used to time watchdog expiry.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural I2C master: answers each presented byte after a random delay.
  initial begin : master_model
    byte_t b;
    int    lat;
    mi = 1'b0; mc = 1'b0; mn = 1'b0; mae = 1'b0; marb = 1'b0; mtr = 1'b1; mrx = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!reset && cur_addr != 8'h00) begin
        if (byte_idx == silent_at) begin
          for (int w = 0; w < 64; w++) begin
            if (reset || cur_addr == 8'h00) break;
            @(negedge clk_in);
          end
        end else begin
          lat = $urandom_range(0, 3);
          repeat (lat) @(negedge clk_in);
          if (byte_q.size() == 0) begin
            check_output("byte_extra", 32'(cur_addr), 32'h0);
          end else begin
            b = byte_q.pop_front();
            check_output("byte_addr", 32'(cur_addr), 32'(b.addr));
            check_output("byte_cont", 32'(cur_cont), 32'(b.cont));
            check_output("byte_start", 32'(cur_start), 32'(b.start));
            if (b.chk_data) check_output("byte_data", 32'(cur_data), 32'(b.data));
            mi = 1'b1;
            case (b.drive)
              F_ADDR:  mae = 1'b1;
              F_ARB:   marb = 1'b1;
              F_NACK:  begin mc = 1'b1; mn = 1'b1; end
              D_READ:  begin mc = 1'b1; mn = 1'b1; mrx = b.rx; end
              default: mc = 1'b1;
            endcase
            @(negedge clk_in);
            mi = 1'b0; mc = 1'b0; mn = 1'b0; mae = 1'b0; marb = 1'b0; mrx = 8'h00;
            clear_cyc = cyc;
            byte_idx++;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk_in);
      if (!reset && cur_rv) begin
        if (rsp_q.size() == 0) begin
          check_output("rsp_unexpected", 32'(cur_rv), 32'h0);
        end else begin
          e = rsp_q.pop_front();
          check_output("rsp_status", 32'(cur_status), 32'(e.status));
          check_output("rsp_rdata", 32'(cur_rdata), 32'(e.rdata));
          check_output("busy_at_rsp", 32'(cur_ready), 32'h0);
          check_output("bytes_left", byte_q.size(), 32'h0);
          if (e.tmo) check_output("timeout_latency", cyc - clear_cyc, 32'd16);
        end
        @(negedge clk_in);
        check_output("rsp_one_cycle", 32'(cur_rv), 32'h0);
        check_output("ready_after_rsp", 32'(cur_ready), 32'h1);
        done_count++;
      end
    end
  end

  // Reference model: lists the bytes the master should see and the final response.
  task automatic apply_stimulus(input logic k, input logic rd_n, input logic [6:0] dev,
                                input logic [15:0] regp, input logic [7:0] wd,
                                input int fault, input int fidx, input logic [7:0] rx,
                                input logic expect_rsp);
    int    n;
    int    start_done;
    byte_t b;
    rsp_t  e;
    sel = k;
    byte_idx = 0;
    silent_at = -1;
    n = k ? 3 : 2;
    e.status = 3'(OK);
    e.rdata  = rd_n ? rx : 8'h00;
    e.tmo    = 1'b0;
    for (int i = 0; i < n; i++) begin
      b.addr     = (i == n - 1 && rd_n) ? {dev, 1'b1} : {dev, 1'b0};
      b.chk_data = !(i == n - 1 && rd_n);
      b.data     = (i == n - 1) ? wd : ((k && i == 0) ? regp[15:8] : regp[7:0]);
      b.cont     = (i < n - 2) ? 1'b1 : ((i == n - 2) ? !rd_n : 1'b0);
      b.start    = (i == 0) || (rd_n && i == n - 2);
      b.rx       = rx;
      b.drive    = (i == n - 1 && rd_n) ? D_READ : F_NONE;
      if (fault != F_NONE && i == fidx) begin
        e.rdata = 8'h00;
        if (fault == F_SILENT) begin
          silent_at = i;
          e.status  = 3'(TIMEOUT);
          e.tmo     = 1'b1;
          break;
        end
        b.drive  = fault;
        e.status = (fault == F_ADDR) ? 3'(ADDR_NACK) : (fault == F_ARB) ? 3'(ARB_LOST) : 3'(DATA_NACK);
        byte_q.push_back(b);
        break;
      end
      byte_q.push_back(b);
    end
    if (expect_rsp) rsp_q.push_back(e);
    start_done = done_count;
    @(negedge clk_in);
    req_valid = 1'b1; req_read = rd_n; req_dev = dev; req_reg = regp; req_wdata = wd;
    for (int w = 0; w < 50 && !cur_ready; w++) @(negedge clk_in);
    check_output("ready_for_req", 32'(cur_ready), 32'h1);
    @(posedge clk_in);
    #1 clear_cyc = cyc;
    @(negedge clk_in);
    req_valid = 1'b0;
    if (expect_rsp) begin
      for (int w = 0; w < 300 && done_count == start_done; w++) @(negedge clk_in);
      check_output("rsp_arrived", 32'(done_count != start_done), 32'h1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_ready"}, 32'(cur_ready), 32'h1);
    check_output({tag, "_rsp_valid"}, 32'(cur_rv), 32'h0);
    check_output({tag, "_rdata"}, 32'(cur_rdata), 32'h0);
    check_output({tag, "_status"}, 32'(cur_status), 32'(OK));
    check_output({tag, "_m_addr"}, 32'(cur_addr), 32'h0);
    check_output({tag, "_m_data"}, 32'(cur_data), 32'h0);
    check_output({tag, "_m_start"}, 32'(cur_start), 32'h0);
    check_output({tag, "_m_cont"}, 32'(cur_cont), 32'h0);
  endtask

  // Stimulus: directed cases followed by randomized transactions.
  initial begin : stimulus
    logic       k, rdn;
    logic [6:0] dev;
    logic [15:0] regp;
    logic [7:0] wd, rx;
    int         fault, fidx, r;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_read = 1'b0;
    req_dev = 7'h00; req_reg = 16'h0000; req_wdata = 8'h00;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    sel = 1'b0; #1 check_reset_state("reset0");
    sel = 1'b1; #1 check_reset_state("reset1");

    apply_stimulus(1'b0, 1'b0, 7'h50, 16'h0012,  8'hA5, F_NONE,   0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b1, 7'h68, 16'h0075,  8'h00, F_NONE,   0, 8'h71, 1'b1);
    apply_stimulus(1'b1, 1'b0, 7'h3C, 16'h1234,  8'h5A, F_NONE,   0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 1'b1, 7'h21, 16'hBEEF,  8'h00, F_NONE,   0, 8'hC3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 7'h50, 16'h0012,  8'hA5, F_ADDR,   0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 1'b1, 7'h11, 16'h0102,  8'h00, F_ADDR,   0, 8'h99, 1'b1);
    apply_stimulus(1'b1, 1'b0, 7'h2A, 16'h4455,  8'h66, F_NACK,   2, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b0, 7'h2B, 16'h0077,  8'h88, F_NACK,   1, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b1, 7'h68, 16'h0075,  8'h00, F_ARB,    0, 8'h71, 1'b1);
    apply_stimulus(1'b1, 1'b0, 7'h33, 16'hA0B0,  8'h01, F_ARB,    1, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b0, 7'h44, 16'h0010,  8'h20, F_SILENT, 0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 1'b1, 7'h45, 16'h0203,  8'h00, F_SILENT, 2, 8'h5E, 1'b1);

    apply_stimulus(1'b0, 1'b0, 7'h46, 16'h0030,  8'h40, F_SILENT, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clk_in);
    check_output("pre_reset_addr", 32'(cur_addr), 32'h8C);
    #2 reset = 1'b1;
    #1 check_reset_state("midreset");
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check_reset_state("after_reset");

    for (int t = 0; t < 40; t++) begin
      k    = 1'($urandom_range(0, 1));
      rdn  = 1'($urandom_range(0, 1));
      dev  = 7'($urandom_range(1, 127));
      regp = 16'($urandom);
      wd   = 8'($urandom);
      rx   = 8'($urandom);
      r    = $urandom_range(0, 9);
      fault = (r < 6) ? F_NONE : (r == 6) ? F_ADDR : (r == 7) ? F_ARB : (r == 8) ? F_NACK : F_SILENT;
      fidx = $urandom_range(0, k ? 2 : 1);
      if (fault == F_NACK && rdn && fidx == (k ? 2 : 1)) fault = F_NONE;
      apply_stimulus(k, rdn, dev, regp, wd, fault, fidx, rx, 1'b1);
    end

    repeat (5) @(negedge clk_in);
    check_output("rsp_queue_empty", rsp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
